// File: rtl/parking_pkg.sv
// Shared lot-state encodings, internal FSM states and default timing for the parking gate controller.
package parking_pkg;

    // Lot state as seen by the slot allocator
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ENTRY = 2'b01,
        EXIT  = 2'b10,
        ALARM = 2'b11
    } lot_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_EXIT,
        S_GATE,
        S_ALARM
    } fsm_state_t;

    localparam int DEF_NUM_SLOTS        = 4;
    localparam int DEF_DEBOUNCE_CYCLES  = 4;
    localparam int DEF_GATE_OPEN_CYCLES = 16;
    localparam int DEF_ALARM_CYCLES     = 8;

    // S_GATE reports IDLE so the allocator only acts on the one-cycle grant states
    function automatic lot_state_t to_lot_state(input fsm_state_t s);
        case (s)
            S_ENTRY: return ENTRY;
            S_EXIT:  return EXIT;
            S_ALARM: return ALARM;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Raw loop sensor conditioning: 2-flop synchronizer, stable-level debounce, rising-edge pulse.
module sensor_debounce
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          sync1, sync2;
    logic          level, level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            // Any return to the accepted level discards the partial run
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit arbitration, barrier timing and full/empty alarms for the parking lot.
// Build option: ALARM_STICKY_EN holds the alarm until alarm_ack instead of timing out.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS        = DEF_NUM_SLOTS,
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int GATE_OPEN_CYCLES = DEF_GATE_OPEN_CYCLES,
    parameter int ALARM_CYCLES     = DEF_ALARM_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 entry_sensor,
    input  logic                 exit_sensor,
    input  logic [NUM_SLOTS-1:0] slots,
    input  logic                 alarm_ack,
    output logic [1:0]           state,
    output logic                 gate_in_open,
    output logic                 gate_out_open,
    output logic                 lot_full,
    output logic                 alarm
);
    localparam int CMAX = (GATE_OPEN_CYCLES > ALARM_CYCLES) ? GATE_OPEN_CYCLES : ALARM_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;

    fsm_state_t    fsm, fsm_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          entry_rise, exit_rise;
    logic          entry_pend, exit_pend;
    logic          entry_clr, exit_clr;
    logic          gin_n, gout_n;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (entry_sensor),
        .rise (entry_rise)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (exit_sensor),
        .rise (exit_rise)
    );

`ifndef ALARM_STICKY_EN
    logic unused_ack;
    assign unused_ack = alarm_ack;
`endif

    always_comb begin
        fsm_n     = fsm;
        cnt_n     = (cnt == CW'(CMAX)) ? cnt : cnt + 1'b1;
        gin_n     = 1'b0;
        gout_n    = 1'b0;
        entry_clr = 1'b0;
        exit_clr  = 1'b0;
        case (fsm)
            S_IDLE: begin
                // Exit wins so a full lot can drain before the next entry is judged
                if (exit_pend) begin
                    exit_clr = 1'b1;
                    fsm_n    = (|slots) ? S_EXIT : S_ALARM;
                end else if (entry_pend) begin
                    entry_clr = 1'b1;
                    fsm_n     = lot_full ? S_ALARM : S_ENTRY;
                end
            end
            S_ENTRY: begin
                fsm_n = S_GATE;
                gin_n = 1'b1;
            end
            S_EXIT: begin
                fsm_n  = S_GATE;
                gout_n = 1'b1;
            end
            S_GATE: begin
                if (cnt == CW'(GATE_OPEN_CYCLES - 1)) begin
                    fsm_n = S_IDLE;
                end else begin
                    gin_n  = gate_in_open;
                    gout_n = gate_out_open;
                end
            end
            S_ALARM: begin
`ifdef ALARM_STICKY_EN
                if (alarm_ack) fsm_n = S_IDLE;
`else
                if (cnt == CW'(ALARM_CYCLES - 1)) fsm_n = S_IDLE;
`endif
            end
            default: fsm_n = S_IDLE;
        endcase
        if (fsm_n != fsm) cnt_n = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm           <= S_IDLE;
            cnt           <= '0;
            entry_pend    <= 1'b0;
            exit_pend     <= 1'b0;
            gate_in_open  <= 1'b0;
            gate_out_open <= 1'b0;
            lot_full      <= 1'b0;
        end else begin
            fsm           <= fsm_n;
            cnt           <= cnt_n;
            entry_pend    <= (entry_pend & ~entry_clr) | entry_rise;
            exit_pend     <= (exit_pend & ~exit_clr) | exit_rise;
            gate_in_open  <= gin_n;
            gate_out_open <= gout_n;
            lot_full      <= &slots;
        end
    end

    assign state = to_lot_state(fsm);
    assign alarm = (fsm == S_ALARM);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed scoreboard bench for parking_gate_ctrl: per-cycle expected output vectors are queued
// alongside each stimulus step and retired one per clock.
module tb_parking_gate_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_sensor = 1'b0;
    logic       exit_sensor = 1'b0;
    logic       alarm_ack = 1'b0;
    logic [3:0] slots = 4'b0000;
    logic [1:0] state;
    logic       gate_in_open, gate_out_open, lot_full, alarm;

    parking_gate_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .entry_sensor  (entry_sensor),
        .exit_sensor   (exit_sensor),
        .slots         (slots),
        .alarm_ack     (alarm_ack),
        .state         (state),
        .gate_in_open  (gate_in_open),
        .gate_out_open (gate_out_open),
        .lot_full      (lot_full),
        .alarm         (alarm)
    );

    always #5 clk = ~clk;

    // {state[1:0], gate_in_open, gate_out_open, lot_full, alarm}
    logic [5:0] obs;
    assign obs = {state, gate_in_open, gate_out_open, lot_full, alarm};

    localparam logic [5:0] O_IDLE  = 6'b00_0_0_0_0;
    localparam logic [5:0] O_ENTRY = 6'b01_0_0_0_0;
    localparam logic [5:0] O_EXIT  = 6'b10_0_0_0_0;
    localparam logic [5:0] O_GIN   = 6'b00_1_0_0_0;
    localparam logic [5:0] O_GOUT  = 6'b00_0_1_0_0;
    localparam logic [5:0] O_FULL  = 6'b00_0_0_1_0;
    localparam logic [5:0] O_ALRMF = 6'b11_0_0_1_1;

    typedef struct {
        string      tag;
        logic [5:0] val;
    } exp_t;

    exp_t sbq[$];
    int   ncmp = 0;
    int   nfail = 0;

    task automatic push(input string tag, input int n, input logic [5:0] v);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tag = tag;
            e.val = v;
            sbq.push_back(e);
        end
    endtask

    task automatic drain(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ncmp++;
            if (sbq.size() == 0) begin
                nfail++;
                $error("FAIL sb_underflow: observed %b required a queued expectation", obs);
            end else begin
                e = sbq.pop_front();
                assert (obs === e.val) else begin
                    nfail++;
                    $error("FAIL %s: observed %b required %b", e.tag, obs, e.val);
                end
            end
        end
    endtask

    initial begin
        // T1: reset held two cycles with sensors toggling
        push("t1_reset", 2, O_IDLE);
        entry_sensor = 1'b1; exit_sensor = 1'b0;
        drain(1);
        entry_sensor = 1'b0; exit_sensor = 1'b1;
        drain(1);
        rst = 1'b0; entry_sensor = 1'b0; exit_sensor = 1'b0;
        push("t1_idle", 5, O_IDLE);
        drain(5);

        // T2: entry on empty lot, 8-cycle latency, 16-cycle gate, single grant
        slots = 4'b0000;
        entry_sensor = 1'b1;
        push("t2_wait", 7, O_IDLE);
        push("t2_entry", 1, O_ENTRY);
        push("t2_gate_in", 16, O_GIN);
        push("t2_after", 21, O_IDLE);
        drain(10);
        entry_sensor = 1'b0;
        drain(35);

        // T3: 2-cycle glitch is discarded
        entry_sensor = 1'b1;
        push("t3_glitch", 20, O_IDLE);
        drain(2);
        entry_sensor = 1'b0;
        drain(18);

        // T4: entry on full lot raises alarm, no gate
        slots = 4'b1111;
        entry_sensor = 1'b1;
        push("t4_full", 7, O_FULL);
`ifdef ALARM_STICKY_EN
        push("t4_alarm", 13, O_ALRMF);
        push("t4_after", 10, O_FULL);
        drain(10);
        entry_sensor = 1'b0;
        drain(10);
        alarm_ack = 1'b1;
        drain(1);
        alarm_ack = 1'b0;
        drain(9);
`else
        push("t4_alarm", 8, O_ALRMF);
        push("t4_after", 15, O_FULL);
        drain(10);
        entry_sensor = 1'b0;
        alarm_ack = 1'b1;
        drain(1);
        alarm_ack = 1'b0;
        drain(19);
`endif

        // T5: simultaneous entry and exit, exit served first
        slots = 4'b0011;
        entry_sensor = 1'b1;
        exit_sensor = 1'b1;
        push("t5_wait", 7, O_IDLE);
        push("t5_exit", 1, O_EXIT);
        push("t5_gate_out", 16, O_GOUT);
        push("t5_idle_gap", 1, O_IDLE);
        push("t5_entry", 1, O_ENTRY);
        push("t5_gate_in", 16, O_GIN);
        push("t5_after", 8, O_IDLE);
        drain(10);
        entry_sensor = 1'b0;
        exit_sensor = 1'b0;
        drain(40);

        // T6: reset in 5th gate cycle with an exit pending; nothing survives
        slots = 4'b0000;
        entry_sensor = 1'b1;
        push("t6_wait", 7, O_IDLE);
        push("t6_entry", 1, O_ENTRY);
        push("t6_gate_in", 5, O_GIN);
        push("t6_after_rst", 27, O_IDLE);
        drain(5);
        exit_sensor = 1'b1;
        drain(5);
        entry_sensor = 1'b0;
        drain(1);
        exit_sensor = 1'b0;
        drain(2);
        rst = 1'b1;
        drain(1);
        rst = 1'b0;
        drain(26);

        ncmp++;
        assert (sbq.size() == 0) else begin
            nfail++;
            $error("FAIL sb_leftover: observed %0d entries required 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
